// File: rtl/branch_predictor_unit.sv
// rtl/branch_predictor_unit.sv - next-PC generator with saturating-counter direction table
// Optional gshare indexing (global history XOR pc index) when GSHARE_EN is defined.
module branch_predictor_unit #(
   parameter int                DATA_W    = 32,
   parameter int                IDX_BITS  = 6,
   parameter int                CNT_BITS  = 2,
   parameter logic [DATA_W-1:0] RESET_PC  = '0,
   parameter int                HIST_BITS = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_fetcher_ena,
   input  logic [DATA_W-1:0] in_last_pc,
   input  logic [DATA_W-1:0] in_last_inst,
   output logic [DATA_W-1:0] out_next_pc,
   output logic              out_next_taken,
   input  logic              in_forwarding_valid,
   input  logic              in_misbranch,
   input  logic              in_forwarding_branch_taken,
   input  logic [DATA_W-1:0] in_forwarding_branch_pc,
   input  logic [DATA_W-1:0] in_forwarding_correct_address,
   output logic              out_clear_all
);

   localparam int                ENTRIES   = 1 << IDX_BITS;
   localparam logic [6:0]        OP_BRANCH = 7'b1100011;
   localparam logic [6:0]        OP_JAL    = 7'b1101111;
   localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

   logic [CNT_BITS-1:0] cnt_q [ENTRIES];
   logic [CNT_BITS-1:0] cnt_d [ENTRIES];
   logic [DATA_W-1:0]   next_pc_q, next_pc_d;
   logic [IDX_BITS-1:0] lookup_idx, update_idx;
   logic [DATA_W-1:0]   b_imm, j_imm, pc_plus4;
   logic                unused_pc_bits;

`ifdef GSHARE_EN
   logic [HIST_BITS-1:0] ghr_q, ghr_d;

   // Both indices hash with the pre-edge history; the shift lands at the clock edge.
   assign lookup_idx = in_last_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
   assign update_idx = in_forwarding_branch_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);

   always_comb begin
      ghr_d = ghr_q;
      if (in_forwarding_valid) begin
         ghr_d = HIST_BITS'({ghr_q, in_forwarding_branch_taken});
      end
   end
`else
   logic [HIST_BITS-1:0] unused_hist;

   assign unused_hist = '0;
   assign lookup_idx  = in_last_pc[IDX_BITS+1:2];
   assign update_idx  = in_forwarding_branch_pc[IDX_BITS+1:2];
`endif

   assign unused_pc_bits = ^{in_forwarding_branch_pc[DATA_W-1:IDX_BITS+2],
                             in_forwarding_branch_pc[1:0]};

   assign b_imm = {{(DATA_W-12){in_last_inst[31]}}, in_last_inst[7],
                   in_last_inst[30:25], in_last_inst[11:8], 1'b0};
   assign j_imm = {{(DATA_W-20){in_last_inst[31]}}, in_last_inst[19:12],
                   in_last_inst[20], in_last_inst[30:21], 1'b0};
   assign pc_plus4 = in_last_pc + DATA_W'(4);

   assign out_next_taken = cnt_q[lookup_idx][CNT_BITS-1];
   assign out_clear_all  = in_misbranch;
   assign out_next_pc    = next_pc_q;

   always_comb begin
      next_pc_d = next_pc_q;
      if (in_fetcher_ena) begin
         if (in_misbranch) begin
            next_pc_d = in_forwarding_correct_address;
         end else if (in_last_inst[6:0] == OP_BRANCH) begin
            next_pc_d = out_next_taken ? (in_last_pc + b_imm) : pc_plus4;
         end else if (in_last_inst[6:0] == OP_JAL) begin
            next_pc_d = in_last_pc + j_imm;
         end else begin
            next_pc_d = pc_plus4;
         end
      end
   end

   // Training follows the resolution bus only; fetch stalls do not block it.
   always_comb begin
      cnt_d = cnt_q;
      if (in_forwarding_valid) begin
         if (in_forwarding_branch_taken) begin
            if (cnt_q[update_idx] != CNT_MAX) begin
               cnt_d[update_idx] = cnt_q[update_idx] + CNT_BITS'(1);
            end
         end else if (cnt_q[update_idx] != '0) begin
            cnt_d[update_idx] = cnt_q[update_idx] - CNT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         next_pc_q <= RESET_PC;
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= CNT_INIT;
         end
`ifdef GSHARE_EN
         ghr_q <= '0;
`endif
      end else begin
         next_pc_q <= next_pc_d;
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
`ifdef GSHARE_EN
         ghr_q <= ghr_d;
`endif
      end
   end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb/tb_branch_predictor_unit.sv - directed self-checking bench for branch_predictor_unit
// Bimodal sequence by default; gshare history/index steps when GSHARE_EN is defined.
module tb_branch_predictor_unit;

   localparam logic [31:0] I_ADDI  = 32'h0000_0013;
   localparam logic [31:0] I_BEQ20 = 32'h0200_0063;
   localparam logic [31:0] I_BEQM8 = 32'hFE00_0CE3;
   localparam logic [31:0] I_JALM16 = 32'hFF1F_F06F;
   localparam logic [31:0] I_JALR  = 32'h0000_8067;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_fetcher_ena;
   logic [31:0] in_last_pc;
   logic [31:0] in_last_inst;
   logic [31:0] out_next_pc;
   logic        out_next_taken;
   logic        in_forwarding_valid;
   logic        in_misbranch;
   logic        in_forwarding_branch_taken;
   logic [31:0] in_forwarding_branch_pc;
   logic [31:0] in_forwarding_correct_address;
   logic        out_clear_all;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_predictor_unit dut (
      .clk                           (clk),
      .rst                           (rst),
      .in_fetcher_ena                (in_fetcher_ena),
      .in_last_pc                    (in_last_pc),
      .in_last_inst                  (in_last_inst),
      .out_next_pc                   (out_next_pc),
      .out_next_taken                (out_next_taken),
      .in_forwarding_valid           (in_forwarding_valid),
      .in_misbranch                  (in_misbranch),
      .in_forwarding_branch_taken    (in_forwarding_branch_taken),
      .in_forwarding_branch_pc       (in_forwarding_branch_pc),
      .in_forwarding_correct_address (in_forwarding_correct_address),
      .out_clear_all                 (out_clear_all)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic train(input logic [31:0] pc, input logic taken);
      in_forwarding_valid        = 1'b1;
      in_forwarding_branch_pc    = pc;
      in_forwarding_branch_taken = taken;
      tick();
      in_forwarding_valid        = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in_fetcher_ena = 1'b1;
      in_last_pc = 32'h0;
      in_last_inst = I_ADDI;
      in_forwarding_valid = 1'b0;
      in_misbranch = 1'b0;
      in_forwarding_branch_taken = 1'b0;
      in_forwarding_branch_pc = 32'h0;
      in_forwarding_correct_address = 32'h0;

      tick();
      check("reset_pc", out_next_pc, 32'h0);
      rst = 1'b0;
      tick();
      check("addi_seq", out_next_pc, 32'h4);

`ifndef GSHARE_EN
      in_last_pc = 32'h100; in_last_inst = I_BEQ20; #1;
      check("beq_init_nt", {31'b0, out_next_taken}, 32'h0);
      tick();
      check("beq_nt_pc", out_next_pc, 32'h104);
      train(32'h100, 1'b1);
      train(32'h100, 1'b1);
      check("beq_trained_t", {31'b0, out_next_taken}, 32'h1);
      tick();
      check("beq_t_pc", out_next_pc, 32'h120);

      in_last_pc = 32'h104;
      for (int i = 0; i < 5; i++) train(32'h104, 1'b1);
      check("sat_hi_taken", {31'b0, out_next_taken}, 32'h1);
      train(32'h104, 1'b0);
      check("sat_one_nt", {31'b0, out_next_taken}, 32'h1);
      train(32'h104, 1'b0);
      train(32'h104, 1'b0);
      check("sat_three_nt", {31'b0, out_next_taken}, 32'h0);
      train(32'h104, 1'b0);
      check("sat_lo_hold", {31'b0, out_next_taken}, 32'h0);
      train(32'h104, 1'b1);
      check("sat_lo_plus1", {31'b0, out_next_taken}, 32'h0);
      train(32'h104, 1'b1);
      check("sat_lo_plus2", {31'b0, out_next_taken}, 32'h1);

      in_last_pc = 32'h200; in_last_inst = I_BEQ20; #1;
      check("alias_taken", {31'b0, out_next_taken}, 32'h1);
      tick();
      check("alias_pc", out_next_pc, 32'h220);

      in_last_pc = 32'h0; in_last_inst = I_BEQM8;
      tick();
      check("wrap_pc", out_next_pc, 32'hFFFF_FFF8);

      in_last_pc = 32'h200; in_last_inst = I_JALM16; #1;
      check("clear_idle", {31'b0, out_clear_all}, 32'h0);
      tick();
      check("jal_pc", out_next_pc, 32'h1F0);
      in_misbranch = 1'b1; in_forwarding_correct_address = 32'h400; #1;
      check("clear_mis", {31'b0, out_clear_all}, 32'h1);
      tick();
      check("mis_pc", out_next_pc, 32'h400);

      in_fetcher_ena = 1'b0;
      in_forwarding_correct_address = 32'h500;
      in_forwarding_branch_taken = 1'b1;
      in_forwarding_branch_pc = 32'h10C;
      tick();
      in_misbranch = 1'b0;
      check("mis_ena0_hold", out_next_pc, 32'h400);
      in_last_pc = 32'h10C; in_last_inst = I_BEQ20; #1;
      check("mis_no_train", {31'b0, out_next_taken}, 32'h0);

      in_last_pc = 32'h108;
      in_forwarding_valid = 1'b1;
      in_forwarding_branch_pc = 32'h108;
      in_forwarding_branch_taken = 1'b1; #1;
      check("same_cycle_old", {31'b0, out_next_taken}, 32'h0);
      tick();
      in_forwarding_valid = 1'b0; #1;
      check("ena0_trained", {31'b0, out_next_taken}, 32'h1);
      check("ena0_hold", out_next_pc, 32'h400);
      in_last_pc = 32'h10A; #1;
      check("pc_low_ignored", {31'b0, out_next_taken}, 32'h1);
      in_fetcher_ena = 1'b1; in_last_pc = 32'h108;
      tick();
      check("ena1_taken_pc", out_next_pc, 32'h128);

      in_last_pc = 32'h300; in_last_inst = I_JALR;
      tick();
      check("jalr_pc", out_next_pc, 32'h304);
`endif

      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun_reset_pc", out_next_pc, 32'h0);
      in_fetcher_ena = 1'b0;
      in_last_pc = 32'h100; in_last_inst = I_BEQ20; #1;
      check("midrun_cnt0", {31'b0, out_next_taken}, 32'h0);
      in_last_pc = 32'h104; #1;
      check("midrun_cnt1", {31'b0, out_next_taken}, 32'h0);

`ifdef GSHARE_EN
      train(32'h100, 1'b1);
      train(32'h100, 1'b1);
      train(32'h100, 1'b0);
      in_last_pc = 32'h100; #1;
      check("gshare_idx6", {31'b0, out_next_taken}, 32'h0);
      in_last_pc = 32'h118; #1;
      check("gshare_idx0", {31'b0, out_next_taken}, 32'h1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
